xband_frame_ctrl: RTL and testbench

Frame sequencer for the X-band link datapath, running entirely in the sys_clk domain. It owns the link reset and the per-frame arm pulse, and latches the expected byte count for the S2MM receive path. It then watches receive progress and both FIFO overflow flags, and declares each frame done or failed. A failed frame gets a timed link reset before the block accepts the next start.

---
 rtl/xband_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_xband_frame_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xband_frame_ctrl.sv
// X-band frame sequencer: link reset, per-frame arm pulse, completion/error tracking.
// States: INIT power-up link reset | IDLE wait start | ARM new_frame high | WAIT receive | DONE | ERROR | RECOVER link reset
module xband_frame_ctrl #(
    parameter int unsigned RST_CYCLES       = 64,
    parameter int unsigned NEW_FRAME_CYCLES = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] exp_bytes,
    input  logic [31:0] timeout_cycles,
    input  logic [31:0] data_cnt,
    input  logic        mm2s_overflow,
    input  logic        s2mm_overflow,
    output logic        xband_rst,
    output logic        new_frame,
    output logic [31:0] exp_bytes_q,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  status,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ARM, S_WAIT, S_DONE, S_ERROR, S_RECOVER
    } state_t;

    localparam logic [31:0] RST_LOAD = 32'(RST_CYCLES - 1);
    localparam logic [31:0] NF_LOAD  = 32'(NEW_FRAME_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] timer_q, timer_d;
    logic        xband_rst_d, new_frame_d, busy_d, done_d, err_d;
    logic [31:0] exp_bytes_d;
    logic [3:0]  status_d;
    logic [15:0] frame_cnt_d, err_cnt_d;
    logic        any_ovf, timed_out, go_err;

    assign any_ovf   = mm2s_overflow | s2mm_overflow;
    assign timed_out = (timeout_cycles != 32'd0) && (timer_q >= timeout_cycles);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        xband_rst_d = xband_rst;
        new_frame_d = new_frame;
        exp_bytes_d = exp_bytes_q;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = 1'b0;
        status_d    = status;
        frame_cnt_d = frame_cnt;
        err_cnt_d   = err_cnt;
        go_err      = 1'b0;

        case (state_q)
            S_INIT: begin
                if (cnt_q == 32'd0) begin
                    state_d     = S_IDLE;
                    xband_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_IDLE: begin
                if (start) begin
                    if (exp_bytes != 32'd0) begin
                        state_d     = S_ARM;
                        exp_bytes_d = exp_bytes;
                        status_d    = 4'b0000;
                        timer_d     = 32'd0;
                        new_frame_d = 1'b1;
                        busy_d      = 1'b1;
                        cnt_d       = NF_LOAD;
                    end else begin
                        err_d       = 1'b1;
                        status_d[3] = 1'b1;
                        err_cnt_d   = err_cnt + 16'd1;
                    end
                end
            end
            S_ARM, S_WAIT: begin
                if (timer_q != 32'hFFFF_FFFF) begin
                    timer_d = timer_q + 32'd1;
                end
                // completion outranks the watchdog, overflow and abort outrank completion
                if (any_ovf) begin
                    go_err      = 1'b1;
                    status_d[1] = status[1] | mm2s_overflow;
                    status_d[2] = status[2] | s2mm_overflow;
                end else if (abort) begin
                    go_err      = 1'b1;
                    status_d[3] = 1'b1;
                end else if ((state_q == S_WAIT) && (data_cnt >= exp_bytes_q)) begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    new_frame_d = 1'b0;
                    frame_cnt_d = frame_cnt + 16'd1;
                end else if (timed_out) begin
                    go_err      = 1'b1;
                    status_d[0] = 1'b1;
                end else if (state_q == S_ARM) begin
                    if (cnt_q == 32'd0) begin
                        state_d     = S_WAIT;
                        new_frame_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                if (go_err) begin
                    state_d     = S_ERROR;
                    err_d       = 1'b1;
                    new_frame_d = 1'b0;
                    err_cnt_d   = err_cnt + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            S_ERROR: begin
                state_d     = S_RECOVER;
                xband_rst_d = 1'b1;
                cnt_d       = RST_LOAD;
            end
            S_RECOVER: begin
                if (cnt_q == 32'd0) begin
                    state_d     = S_IDLE;
                    xband_rst_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d     = S_INIT;
                xband_rst_d = 1'b1;
                cnt_d       = RST_LOAD;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= S_INIT;
            cnt_q       <= RST_LOAD;
            timer_q     <= 32'd0;
            xband_rst   <= 1'b1;
            new_frame   <= 1'b0;
            exp_bytes_q <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            status      <= 4'b0000;
            frame_cnt   <= 16'd0;
            err_cnt     <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            xband_rst   <= xband_rst_d;
            new_frame   <= new_frame_d;
            exp_bytes_q <= exp_bytes_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            status      <= status_d;
            frame_cnt   <= frame_cnt_d;
            err_cnt     <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_xband_frame_ctrl.sv
// Bench for xband_frame_ctrl: directed frames, scoreboard of expected done/err pulses.
module tb_xband_frame_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] exp_bytes = '0;
    logic [31:0] timeout_cycles = '0;
    logic [31:0] data_cnt = '0;
    logic        mm2s_overflow = 1'b0;
    logic        s2mm_overflow = 1'b0;
    logic        xband_rst, new_frame, busy, done, err;
    logic [31:0] exp_bytes_q;
    logic [3:0]  status;
    logic [15:0] frame_cnt, err_cnt;

    xband_frame_ctrl #(.RST_CYCLES(64), .NEW_FRAME_CYCLES(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
        .exp_bytes(exp_bytes), .timeout_cycles(timeout_cycles), .data_cnt(data_cnt),
        .mm2s_overflow(mm2s_overflow), .s2mm_overflow(s2mm_overflow),
        .xband_rst(xband_rst), .new_frame(new_frame), .exp_bytes_q(exp_bytes_q),
        .busy(busy), .done(done), .err(err), .status(status),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        int          at_cyc;
        logic [3:0]  st;
        logic [15:0] fcnt;
        logic [15:0] ecnt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // monitor: every done/err pulse must match the oldest expected event
    always @(negedge sys_clk) begin
        if (!sys_rst && (done || err)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none (cycle %0d)", done, err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
                chk("pulse_cycle", cyc, e.at_cyc);
                chk("pulse_status", {28'd0, status}, {28'd0, e.st});
                chk("pulse_frame_cnt", {16'd0, frame_cnt}, {16'd0, e.fcnt});
                chk("pulse_err_cnt", {16'd0, err_cnt}, {16'd0, e.ecnt});
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge sys_clk);
    endtask

    task automatic push(input bit is_err, input int at, input logic [3:0] st,
                        input logic [15:0] fc, input logic [15:0] ec);
        exp_t e;
        e.is_err = is_err; e.at_cyc = at; e.st = st; e.fcnt = fc; e.ecnt = ec;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] bytes, output int n);
        start = 1'b1;
        exp_bytes = bytes;
        n = cyc;
        tick(1);
        start = 1'b0;
    endtask

    // number of sampling edges for which xband_rst stays high, starting now
    task automatic count_high(output int k);
        k = 0;
        for (int i = 0; i < 300; i++) begin
            if (!xband_rst) break;
            k++;
            @(negedge sys_clk);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_xband_rst"}, {31'd0, xband_rst}, 32'd1);
        chk({tag, "_new_frame"}, {31'd0, new_frame}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_err"}, {30'd0, done, err}, 32'd0);
        chk({tag, "_status"}, {28'd0, status}, 32'd0);
        chk({tag, "_exp_bytes_q"}, exp_bytes_q, 32'd0);
        chk({tag, "_counts"}, {frame_cnt, err_cnt}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, k;

        // power-up
        tick(3);
        chk_reset_vals("por");
        sys_rst = 1'b0;
        count_high(k);
        chk("por_xband_rst_len", k, 64);
        chk("por_idle_busy", {31'd0, busy}, 32'd0);

        // abort in IDLE is ignored
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);
        chk("idle_abort_err_cnt", {16'd0, err_cnt}, 32'd0);
        tick(1);

        // zero-length start is rejected
        push(1'b1, cyc + 1, 4'b1000, 16'd0, 16'd1);
        do_start(32'd0, n);
        chk("reject_busy", {31'd0, busy}, 32'd0);
        tick(1);
        chk("reject_stay_idle", {30'd0, busy, new_frame}, 32'd0);

        // normal frame of 1024 bytes, with a start issued during WAIT
        data_cnt = 32'd0;
        do_start(32'd1024, n);
        exp_bytes = 32'd0;
        chk("norm_exp_bytes_q", exp_bytes_q, 32'd1024);
        chk("norm_new_frame_n1", {31'd0, new_frame}, 32'd1);
        chk("norm_busy_n1", {31'd0, busy}, 32'd1);
        tick(3);
        chk("norm_new_frame_n4", {31'd0, new_frame}, 32'd1);
        tick(1);
        chk("norm_new_frame_n5", {31'd0, new_frame}, 32'd0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("wait_start_ignored", exp_bytes_q, 32'd1024);
        data_cnt = 32'd256;  tick(1);
        data_cnt = 32'd768;  tick(1);
        data_cnt = 32'd1023; tick(2);
        chk("norm_below_busy", {31'd0, busy}, 32'd1);
        push(1'b0, cyc + 1, 4'b0000, 16'd1, 16'd1);
        data_cnt = 32'd1024;
        tick(1);
        data_cnt = 32'd0;
        chk("norm_done_busy", {31'd0, busy}, 32'd1);
        tick(1);
        chk("norm_busy_fall", {31'd0, busy}, 32'd0);

        // watchdog timeout
        timeout_cycles = 32'd100;
        push(1'b1, cyc + 102, 4'b0001, 16'd1, 16'd2);
        do_start(32'd1024, n);
        tick(101);
        chk("tmo_xband_rst_at_err", {31'd0, xband_rst}, 32'd0);
        tick(1);
        count_high(k);
        chk("tmo_xband_rst_len", k, 64);
        chk("tmo_busy_fall_cycle", cyc, n + 167);
        chk("tmo_busy_fall", {31'd0, busy}, 32'd0);
        timeout_cycles = 32'd0;

        // overflow races completion in WAIT
        do_start(32'd16, n);
        tick(6);
        s2mm_overflow = 1'b1;
        data_cnt = 32'd16;
        push(1'b1, cyc + 1, 4'b0100, 16'd1, 16'd3);
        tick(1);
        s2mm_overflow = 1'b0;
        data_cnt = 32'd0;
        tick(64);
        chk("ovf_busy_recover", {31'd0, busy}, 32'd1);
        tick(1);
        chk("ovf_busy_fall", {31'd0, busy}, 32'd0);
        chk("ovf_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // both overflows during ARM
        do_start(32'd16, n);
        tick(1);
        mm2s_overflow = 1'b1;
        s2mm_overflow = 1'b1;
        push(1'b1, cyc + 1, 4'b0110, 16'd1, 16'd4);
        tick(1);
        mm2s_overflow = 1'b0;
        s2mm_overflow = 1'b0;
        chk("arm_ovf_new_frame", {31'd0, new_frame}, 32'd0);
        tick(65);
        chk("arm_ovf_busy_fall", {31'd0, busy}, 32'd0);

        // abort outranks completion in WAIT
        do_start(32'd16, n);
        tick(7);
        abort = 1'b1;
        data_cnt = 32'd16;
        push(1'b1, cyc + 1, 4'b1000, 16'd1, 16'd5);
        tick(1);
        abort = 1'b0;
        data_cnt = 32'd0;
        tick(65);
        chk("abort_busy_fall", {31'd0, busy}, 32'd0);

        // completion and timeout in the same cycle
        timeout_cycles = 32'd20;
        do_start(32'd16, n);
        tick(20);
        data_cnt = 32'd16;
        push(1'b0, cyc + 1, 4'b0000, 16'd2, 16'd5);
        tick(1);
        data_cnt = 32'd0;
        tick(1);
        chk("race_tmo_busy_fall", {31'd0, busy}, 32'd0);
        timeout_cycles = 32'd0;

        // reset in the middle of a frame
        do_start(32'd64, n);
        tick(8);
        sys_rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tick(2);
        sys_rst = 1'b0;
        count_high(k);
        chk("midrst_xband_rst_len", k, 64);

        tick(2);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
